// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter with a runtime baud divisor.
// Frames run back to back while enabled and bytes are queued.
module uart_tx_fifo #(
    parameter int DEPTH     = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   enable,
    input  logic [DIV_WIDTH-1:0]   clk_div,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   ser_tx,
    output logic                   busy,
    output logic                   tx_done,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] P_ONE = (AW+1)'(1);
    localparam logic [DIV_WIDTH-1:0] D_ONE = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] D_TWO = DIV_WIDTH'(2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state, w_state;
    logic [DIV_WIDTH-1:0] r_cnt, w_cnt, r_div, w_div, w_div_eff;
    logic [2:0]           r_bit, w_bit;
    logic [7:0]           r_shift, w_shift;
    logic                 r_ser, w_ser, r_rdy;
    logic [AW:0]          r_wptr, r_rptr, w_level;
    logic                 w_push, w_pop, w_go, w_bit_end;
    logic [7:0]           r_mem [DEPTH];

    assign w_level    = r_wptr - r_rptr;
    assign w_push     = tx_valid && tx_ready;
    assign w_go       = enable && (w_level != '0);
    assign w_bit_end  = (r_cnt == '0);
    assign w_div_eff  = (clk_div < D_TWO) ? D_TWO : clk_div;
    assign tx_ready   = r_rdy && (w_level < FULL);
    assign ser_tx     = r_ser;
    assign busy       = (r_state != IDLE);
    assign tx_done    = (r_state == STOP) && w_bit_end;
    assign fifo_level = w_level;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_div   = r_div;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_ser   = r_ser;
        w_pop   = 1'b0;
        case (r_state)
            IDLE:  w_pop = w_go;
            START: begin
                w_cnt = w_bit_end ? r_div - D_ONE : r_cnt - D_ONE;
                if (w_bit_end) begin
                    w_state = DATA;
                    w_bit   = '0;
                    w_ser   = r_shift[0];
                    w_shift = r_shift >> 1;
                end
            end
            DATA: begin
                w_cnt = w_bit_end ? r_div - D_ONE : r_cnt - D_ONE;
                if (w_bit_end) begin
                    w_state = (r_bit == 3'd7) ? STOP : DATA;
                    w_bit   = r_bit + 3'd1;
                    w_ser   = (r_bit == 3'd7) ? 1'b1 : r_shift[0];
                    w_shift = r_shift >> 1;
                end
            end
            default: begin
                w_cnt   = r_cnt - D_ONE;
                w_state = w_bit_end ? IDLE : STOP;
                w_pop   = w_bit_end && w_go;
            end
        endcase
        // Starting a frame latches the divisor so mid-frame clk_div changes are ignored.
        if (w_pop) begin
            w_state = START;
            w_ser   = 1'b0;
            w_shift = r_mem[r_rptr[AW-1:0]];
            w_div   = w_div_eff;
            w_cnt   = w_div_eff - D_ONE;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= D_TWO;
            r_bit   <= '0;
            r_shift <= '0;
            r_ser   <= 1'b1;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_ser   <= w_ser;
            r_wptr  <= w_push ? r_wptr + P_ONE : r_wptr;
            r_rptr  <= w_pop ? r_rptr + P_ONE : r_rptr;
            r_rdy   <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push)
            r_mem[r_wptr[AW-1:0]] <= tx_data;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a serial-line monitor decodes frames and checks them against queued bytes.
module tb_uart_tx_fifo;
    logic        clk = 1'b0, rst = 1'b0, enable = 1'b1, tx_valid = 1'b0;
    logic [15:0] clk_div = 16'd4;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready, ser_tx, busy, tx_done;
    logic [2:0]  fifo_level;

    int          n_cmp = 0, n_bad = 0, cyc = 0, m_done_cnt = 0, m_k = 0, m_n = 2;
    bit          m_act = 1'b0;
    logic        m_lvl = 1'b1;
    logic [7:0]  m_byte = 8'h00;
    logic [7:0]  sb[$];
    int          dq[$];

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .clk_div(clk_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .ser_tx(ser_tx),
        .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input logic [15:0] d);
        return (d < 16'd2) ? 2 : int'(d);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        tx_data = b;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", tx_ready, 1);
        if (tx_ready) sb.push_back(b);
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int t = 0;
        while (m_done_cnt < target && t < budget) begin
            @(posedge clk);
            t++;
        end
        #1 chk(tag, m_done_cnt, target);
    endtask

    // Monitor: one sample per cycle on the falling edge, frame length taken from clk_div at start.
    always @(negedge clk) begin
        int b, p;
        cyc++;
        if (rst) begin
            m_act = 1'b0;
        end else begin
            if (tx_done) begin
                m_done_cnt++;
                dq.push_back(cyc);
            end
            if (!m_act && ser_tx == 1'b0) begin
                m_act = 1'b1;
                m_k = 0;
                m_n = eff(clk_div);
            end
            chk("busy", busy, m_act);
            if (m_act) begin
                b = m_k / m_n;
                p = m_k % m_n;
                if (p == 0) m_lvl = ser_tx;
                else chk("bit_stable", ser_tx, m_lvl);
                if (b >= 1 && b <= 8 && p == 0) m_byte[b-1] = ser_tx;
                if (b == 9 && p == 0) chk("stop_bit", ser_tx, 1);
                chk("tx_done_time", tx_done, m_k == 10 * m_n - 1);
                if (m_k == 10 * m_n - 1) begin
                    m_act = 1'b0;
                    chk("frame_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) chk("rx_byte", m_byte, sb.pop_front());
                end
                m_k++;
            end else begin
                chk("idle_done", tx_done, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, c0, low, t;
        #1 rst = 1'b1;
        #1;
        chk("rst_ser", ser_tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", tx_ready, 0);
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_pre_edge", tx_ready, 0);
        tick();
        chk("ready_after_edge", tx_ready, 1);

        // single byte, latency and 40-cycle frame
        push(8'hA5);
        chk("a_level", fifo_level, 1);
        chk("a_ser_hold", ser_tx, 1);
        tick();
        chk("a_ser_low", ser_tx, 0);
        chk("a_busy", busy, 1);
        chk("a_level0", fifo_level, 0);
        c0 = cyc;
        wait_done(1, 60, "a_done");
        chk("a_len", dq[$] - c0, 40);
        tick(2);
        chk("a_busy_after", busy, 0);
        chk("a_sb_empty", sb.size(), 0);

        // five back-to-back bytes, FIFO full, refused push
        base = m_done_cnt;
        c0 = cyc;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        chk("b_level_full", fifo_level, 4);
        chk("b_ready_low", tx_ready, 0);
        tx_data = 8'hEE;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("b_full_refuse", fifo_level, 4);
        low = 0;
        t = 0;
        while (m_done_cnt < base + 5 && t < 300) begin
            tick();
            if (!busy && m_done_cnt < base + 5) low++;
            t++;
        end
        chk("b_done5", m_done_cnt, base + 5);
        chk("b_gapless", low, 0);
        chk("b_span", dq[$] - c0, 202);
        chk("b_sb_empty", sb.size(), 0);
        tick(3);

        // divisor 0 and 1 behave as 2
        for (int d = 0; d < 2; d++) begin
            clk_div = 16'(d);
            base = m_done_cnt;
            push(8'hFF);
            tick();
            chk("c_start0", ser_tx, 0);
            tick();
            chk("c_start1", ser_tx, 0);
            tick();
            chk("c_data0", ser_tx, 1);
            wait_done(base + 1, 40, "c_done");
            tick(2);
        end

        // divisor change mid-frame affects only the next frame
        clk_div = 16'd4;
        base = m_done_cnt;
        push(8'h3C);
        push(8'hC3);
        tick(10);
        clk_div = 16'd8;
        wait_done(base + 2, 200, "d_done2");
        chk("d_len2", dq[$] - dq[$-1], 80);
        clk_div = 16'd4;
        tick(3);

        // reset during DATA discards everything
        base = m_done_cnt;
        push(8'h01); push(8'h02); push(8'h03);
        tick(10);
        chk("e_level", fifo_level, 2);
        chk("e_busy", busy, 1);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("e_rst_ser", ser_tx, 1);
        chk("e_rst_level", fifo_level, 0);
        chk("e_rst_busy", busy, 0);
        chk("e_rst_ready", tx_ready, 0);
        tick(2);
        rst = 1'b0;
        tick(50);
        chk("e_no_done", m_done_cnt, base);
        chk("e_ser_idle", ser_tx, 1);
        chk("e_level0", fifo_level, 0);
        push(8'h5A);
        wait_done(base + 1, 60, "e_new_done");
        chk("e_sb_empty", sb.size(), 0);
        tick(3);

        // enable gating, mid-frame disable retains queue
        enable = 1'b0;
        base = m_done_cnt;
        push(8'h61); push(8'h62); push(8'h63);
        tick(20);
        chk("f_ser_idle", ser_tx, 1);
        chk("f_level3", fifo_level, 3);
        chk("f_busy0", busy, 0);
        enable = 1'b1;
        tick();
        chk("f_start", ser_tx, 0);
        chk("f_level2", fifo_level, 2);
        enable = 1'b0;
        wait_done(base + 1, 60, "f_one_done");
        tick(50);
        chk("f_retained", fifo_level, 2);
        chk("f_idle", busy, 0);
        chk("f_no_more", m_done_cnt, base + 1);
        enable = 1'b1;
        wait_done(base + 3, 120, "f_drain");
        chk("f_sb_empty", sb.size(), 0);
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of FIFO byte entries (power of two, 2..16).
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-003 wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 wb_rst_i  input  1  reset, asynchronous and active-high.
REQ-005 enable  input  1  when high, new frames may start.
REQ-006 clk_div  input  DIV_WIDTH  clock cycles per serial bit; values 0 and 1 are treated as 2.
REQ-007 tx_data  input  8  byte to transmit.
REQ-008 tx_valid  input  1  tx_data is valid this cycle.
REQ-009 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-010 ser_tx  output  1  registered serial line (8N1, idle high).
REQ-011 busy  output  1  a frame is in progress.
REQ-012 tx_done  output  1  one-cycle pulse at the end of each stop bit.
REQ-013 fifo_level  output  $clog2(DEPTH)+1  number of bytes queued, excluding the byte in flight.

Function
REQ-014 A byte SHALL be accepted only on an edge where tx_valid && tx_ready; tx_valid without tx_ready SHALL have no effect.
REQ-015 tx_ready SHALL equal (fifo_level < DEPTH), with no full-FIFO bypass: push is refused while full even if a pop occurs on the same edge.
REQ-016 A push and a pop on the same edge SHALL leave fifo_level unchanged and preserve byte order.
REQ-017 FIFO read and write pointers SHALL wrap modulo DEPTH; an extra MSB SHALL distinguish full from empty.
REQ-018 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-019 IDLE -> START SHALL occur on the first edge where enable && fifo_level > 0; that edge pops the head byte into the shift register, latches the effective clk_div into the bit counter reload, and drives ser_tx low.
REQ-020 START SHALL hold ser_tx=0 for N cycles (N = latched divisor), then enter DATA.
REQ-021 DATA SHALL send 8 bits LSB first, each for N cycles, counted by a 3-bit bit index; after bit 7 it SHALL enter STOP.
REQ-022 STOP SHALL hold ser_tx=1 for N cycles; on its last cycle tx_done SHALL pulse for exactly one cycle.
REQ-023 Out of STOP, if enable && fifo_level > 0, the FSM SHALL go directly to START with no idle gap; otherwise it SHALL go to IDLE.
REQ-024 A frame SHALL last exactly 10*N cycles; changes to clk_div during a frame SHALL not affect that frame.
REQ-025 Deasserting enable mid-frame SHALL let the current frame complete; no new frame starts while enable is low, and queued bytes are retained.
REQ-026 Latency: a byte pushed into an empty FIFO while IDLE and enabled SHALL drive ser_tx low from the edge after the accepting edge.
REQ-027 busy SHALL be high exactly when the state is not IDLE.

Reset
REQ-028 On wb_rst_i assertion, the block SHALL immediately set ser_tx=1, busy=0, tx_done=0, fifo_level=0, tx_ready=0, and state=IDLE, and SHALL clear the FIFO pointers and the counters.
REQ-029 Reset mid-frame SHALL abort the frame with no stop-bit completion and SHALL discard all queued bytes.
REQ-030 After reset deasserts, tx_ready SHALL rise on the first clock edge.

Verification
REQ-031 clk_div=4, push 0xA5 while IDLE -> ser_tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total); tx_done pulses once at cycle 40; busy low afterwards.
REQ-032 clk_div=4, push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> tx_ready drops when fifo_level=4; all five bytes are sent in order with no idle cycles between frames (200 cycles); five tx_done pulses.
REQ-033 clk_div=0 and clk_div=1 -> each bit lasts 2 cycles; 0xFF yields 2 cycles low then 18 cycles high.
REQ-034 Mid-frame clk_div change from 4 to 8 -> current frame stays at 40 cycles; the next frame is 80 cycles.
REQ-035 Assert wb_rst_i during DATA with 2 bytes queued -> ser_tx=1 and fifo_level=0 immediately; no tx_done; the next push transmits only the new byte.
REQ-036 enable low with 3 bytes pushed -> ser_tx stays 1 and fifo_level=3; raising enable starts transmission on the next edge.
